// File: rtl/armleocpu_defs.sv
// armleocpu_defs: shared widths, register-zero constant and arbiter defaults
package armleocpu_defs;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int STARVE_LIMIT_DEFAULT = 4;
endpackage

// File: rtl/armleocpu_regfile_scoreboard.sv
// armleocpu_regfile_scoreboard: busy vector for in-flight long-unit results
// with two hazard read ports and a sticky double-issue error flag.
module armleocpu_regfile_scoreboard
   import armleocpu_defs::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_i,
   input  logic [REG_ADDR_W-1:0] set_addr_i,
   input  logic                  clr_i,
   input  logic [REG_ADDR_W-1:0] clr_addr_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o,
   output logic [31:0]           busy_o,
   output logic                  sb_err_o
);
   logic [31:0] busy_q, busy_d, set_mask, clr_mask;
   logic        sb_err_q, sb_err_d, set_en, clr_en;
   always_comb begin
      set_en   = set_i && set_addr_i != REG_ZERO;
      clr_en   = clr_i && clr_addr_i != REG_ZERO;
      set_mask = set_en ? (32'd1 << set_addr_i) : 32'd0;
      clr_mask = clr_en ? (32'd1 << clr_addr_i) : 32'd0;
      // set is applied after clear so a same-address set wins
      busy_d   = (busy_q & ~clr_mask) | set_mask;
      sb_err_d = sb_err_q | (set_en && busy_q[set_addr_i] && !(clr_en && clr_addr_i == set_addr_i));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         sb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         sb_err_q <= sb_err_d;
      end
   end
   assign rs1_busy_o = busy_q[rs1_addr_i];
   assign rs2_busy_o = busy_q[rs2_addr_i];
   assign busy_o     = busy_q;
   assign sb_err_o   = sb_err_q;
endmodule

// File: rtl/armleocpu_regfile_wb_arbiter.sv
// armleocpu_regfile_wb_arbiter: shares the regfile write port between execute
// and the long-latency unit, with WAW protection and bounded starvation.
module armleocpu_regfile_wb_arbiter
   import armleocpu_defs::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  exec_wr_valid,
   input  logic [REG_ADDR_W-1:0] exec_wr_addr,
   input  logic [XLEN-1:0]       exec_wr_data,
   output logic                  exec_stall,
   input  logic                  lu_wr_valid,
   input  logic [REG_ADDR_W-1:0] lu_wr_addr,
   input  logic [XLEN-1:0]       lu_wr_data,
   output logic                  lu_wr_ready,
   input  logic                  sb_set,
   input  logic [REG_ADDR_W-1:0] sb_set_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  sb_err,
   output logic                  rd_write,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_wdata
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] busy;
   logic        exec_wants, waw, starved, exec_grant, lu_grant, lu_write;
   armleocpu_regfile_scoreboard u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (sb_set),
      .set_addr_i (sb_set_addr),
      .clr_i      (lu_grant),
      .clr_addr_i (lu_wr_addr),
      .rs1_addr_i (rs1_addr),
      .rs2_addr_i (rs2_addr),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .busy_o     (busy),
      .sb_err_o   (sb_err)
   );
   // combinational outputs are forced low while reset is held
   always_comb begin
      exec_wants = rst_n && exec_wr_valid && exec_wr_addr != REG_ZERO;
      waw        = busy[exec_wr_addr];
      starved    = wait_cnt_q == LIMIT;
      exec_grant = exec_wants && !waw && !(starved && lu_wr_valid);
      lu_grant   = rst_n && lu_wr_valid && !exec_grant;
      lu_write   = lu_grant && lu_wr_addr != REG_ZERO;
      lu_wr_ready = lu_grant;
      exec_stall = exec_wants && !exec_grant;
      rd_write   = exec_grant || lu_write;
      rd_addr    = exec_grant ? exec_wr_addr : lu_write ? lu_wr_addr : REG_ZERO;
      rd_wdata   = exec_grant ? exec_wr_data : lu_write ? lu_wr_data : '0;
      wait_cnt_d = lu_grant ? 4'd0
                 : (lu_wr_valid && !starved) ? wait_cnt_q + 4'd1
                 : wait_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt_q <= 4'd0;
      else wait_cnt_q <= wait_cnt_d;
   end
endmodule

// File: tb/tb_armleocpu_regfile_wb_arbiter.sv
// tb_armleocpu_regfile_wb_arbiter: directed checks of arbitration, scoreboard,
// starvation, x0 handling and asynchronous reset.
module tb_armleocpu_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        exec_wr_valid, lu_wr_valid, sb_set;
   logic [4:0]  exec_wr_addr, lu_wr_addr, sb_set_addr, rs1_addr, rs2_addr;
   logic [31:0] exec_wr_data, lu_wr_data;
   logic        exec_stall, lu_wr_ready, rs1_busy, rs2_busy, sb_err, rd_write;
   logic [4:0]  rd_addr;
   logic [31:0] rd_wdata;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   armleocpu_regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .exec_wr_valid(exec_wr_valid), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
      .exec_stall(exec_stall),
      .lu_wr_valid(lu_wr_valid), .lu_wr_addr(lu_wr_addr), .lu_wr_data(lu_wr_data),
      .lu_wr_ready(lu_wr_ready),
      .sb_set(sb_set), .sb_set_addr(sb_set_addr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .sb_err(sb_err), .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      exec_wr_valid = 1'b1; exec_wr_addr = 5'd5; exec_wr_data = 32'hDEADBEEF;
      lu_wr_valid = 1'b0; lu_wr_addr = 5'd0; lu_wr_data = 32'd0;
      sb_set = 1'b0; sb_set_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      #3;
      chk("rst_rd_write", rd_write, 0);
      chk("rst_stall", exec_stall, 0);
      chk("rst_sb_err", sb_err, 0);
      #4 rst_n = 1'b1;
      #1;
      chk("exec_rd_write", rd_write, 1);
      chk("exec_rd_addr", rd_addr, 5);
      chk("exec_rd_wdata", rd_wdata, 32'hDEADBEEF);
      chk("exec_stall0", exec_stall, 0);
      tick();
      exec_wr_valid = 1'b0; sb_set = 1'b1; sb_set_addr = 5'd7; rs1_addr = 5'd7;
      #1 chk("no_bypass_set", rs1_busy, 0);
      tick();
      sb_set = 1'b0;
      exec_wr_valid = 1'b1; exec_wr_addr = 5'd7; exec_wr_data = 32'h22;
      #1;
      chk("busy7", rs1_busy, 1);
      chk("waw_stall", exec_stall, 1);
      chk("waw_no_write", rd_write, 0);
      tick();
      lu_wr_valid = 1'b1; lu_wr_addr = 5'd7; lu_wr_data = 32'h11;
      #1;
      chk("waw_lu_ready", lu_wr_ready, 1);
      chk("waw_lu_addr", rd_addr, 7);
      chk("waw_lu_data", rd_wdata, 32'h11);
      chk("waw_still_stall", exec_stall, 1);
      tick();
      lu_wr_valid = 1'b0;
      #1;
      chk("busy7_cleared", rs1_busy, 0);
      chk("exec_commit_stall", exec_stall, 0);
      chk("exec_commit_data", rd_wdata, 32'h22);
      tick();
      exec_wr_addr = 5'd3; exec_wr_data = 32'h33;
      lu_wr_valid = 1'b1; lu_wr_addr = 5'd8; lu_wr_data = 32'h88;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_blocked", lu_wr_ready, 0);
         chk("starve_exec_addr", rd_addr, 3);
         tick();
      end
      #1;
      chk("starved_lu_ready", lu_wr_ready, 1);
      chk("starved_exec_stall", exec_stall, 1);
      chk("starved_rd_addr", rd_addr, 8);
      tick();
      lu_wr_valid = 1'b0;
      #1;
      chk("resume_stall", exec_stall, 0);
      chk("resume_rd_addr", rd_addr, 3);
      tick();
      exec_wr_valid = 1'b0;
      sb_set = 1'b1; sb_set_addr = 5'd9;
      tick();
      lu_wr_valid = 1'b1; lu_wr_addr = 5'd9; lu_wr_data = 32'h99;
      #1 chk("same_cycle_ready", lu_wr_ready, 1);
      tick();
      sb_set = 1'b0; lu_wr_valid = 1'b0; rs1_addr = 5'd9;
      #1;
      chk("set_wins_busy9", rs1_busy, 1);
      chk("set_wins_no_err", sb_err, 0);
      sb_set = 1'b1; sb_set_addr = 5'd4;
      tick();
      tick();
      sb_set = 1'b0; rs2_addr = 5'd4;
      #1;
      chk("double_set_err", sb_err, 1);
      chk("busy4", rs2_busy, 1);
      tick();
      tick();
      exec_wr_valid = 1'b1; exec_wr_addr = 5'd0; exec_wr_data = 32'h5;
      lu_wr_valid = 1'b1; lu_wr_addr = 5'd0; lu_wr_data = 32'h6;
      rs1_addr = 5'd0;
      #1;
      chk("err_sticky", sb_err, 1);
      chk("x0_rd_write", rd_write, 0);
      chk("x0_lu_ready", lu_wr_ready, 1);
      chk("x0_stall", exec_stall, 0);
      chk("x0_rs1_busy", rs1_busy, 0);
      tick();
      exec_wr_valid = 1'b0; lu_wr_valid = 1'b0;
      sb_set = 1'b1; sb_set_addr = 5'd12;
      tick();
      sb_set = 1'b0;
      exec_wr_valid = 1'b1; exec_wr_addr = 5'd5;
      lu_wr_valid = 1'b1; lu_wr_addr = 5'd12; rs1_addr = 5'd12;
      #1 chk("busy12", rs1_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_write", rd_write, 0);
      chk("mid_rst_lu_ready", lu_wr_ready, 0);
      chk("mid_rst_stall", exec_stall, 0);
      chk("mid_rst_rs1_busy", rs1_busy, 0);
      chk("mid_rst_sb_err", sb_err, 0);
      exec_wr_valid = 1'b0; lu_wr_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy12", rs1_busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/armleocpu_regfile_wb_arbiter.md
Name: armleocpu_regfile_wb_arbiter

Overview:
- Arbitrates the single regfile write port (rd_write/rd_addr/rd_wdata) between two writeback sources:
  - the single-cycle execute stage;
  - the long-latency unit (load/mul/div).
- Holds a 32-entry scoreboard of registers with an in-flight long-latency result.
- Reports read hazards for rs1/rs2 to decode.
- Prevents write-after-write reordering.
- Bounds long-unit starvation with a wait counter.

Parameters:
- STARVE_LIMIT, 4, number of consecutive blocked long-unit cycles after which the long unit takes priority over execute. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- exec_wr_valid  in  1  execute stage has a result to write.
- exec_wr_addr  in  5  execute destination register.
- exec_wr_data  in  32  execute result.
- exec_stall  out  1  execute write not taken this cycle; execute holds its inputs.
- lu_wr_valid  in  1  long unit has a result.
- lu_wr_addr  in  5  long unit destination register.
- lu_wr_data  in  32  long unit result.
- lu_wr_ready  out  1  long unit result accepted this cycle.
- sb_set  in  1  decode issues a long op; marks sb_set_addr busy.
- sb_set_addr  in  5  destination register of the issued long op.
- rs1_addr  in  5  decode source 1.
- rs2_addr  in  5  decode source 2.
- rs1_busy  out  1  rs1 has a pending long-unit write.
- rs2_busy  out  1  rs2 has a pending long-unit write.
- sb_err  out  1  sticky flag: sb_set hit a register that was already busy.
- rd_write  out  1  regfile write enable.
- rd_addr  out  5  regfile write address.
- rd_wdata  out  32  regfile write data.

Behaviour:
- State:
  - busy[31:0] scoreboard;
  - wait_cnt, 4 bits;
  - sb_err.
- Reset (async, rst_n low):
  - busy=0, wait_cnt=0, sb_err=0.
  - All outputs 0: rd_write, lu_wr_ready, exec_stall, rs1_busy, rs2_busy, sb_err.
- Combinational signals:
  - exec_wants = exec_wr_valid && exec_wr_addr!=0.
  - waw = busy[exec_wr_addr].
  - starved = (wait_cnt==STARVE_LIMIT).
- Grant:
  - exec_grant = exec_wants && !waw && !(starved && lu_wr_valid).
  - lu_grant = lu_wr_valid && !exec_grant.
  - lu_wr_ready = lu_grant.
  - exec_stall = exec_wants && !exec_grant.
- Write port, zero-latency combinational:
  - exec_grant → execute addr/data.
  - lu_grant with lu_wr_addr!=0 → long unit addr/data.
  - Otherwise rd_write=0, and rd_addr/rd_wdata=0.
- x0 rules:
  - An execute write to x0 is dropped: no stall, no port use.
  - A long-unit write to x0 is accepted when granted, with rd_write=0.
  - sb_set to x0 is ignored.
  - rs*_busy is always 0 for x0.
- Scoreboard update, per rising edge:
  - On a long-unit handshake, clear busy[lu_wr_addr].
  - On sb_set, set busy[sb_set_addr].
  - If both target the same address in one cycle, set wins.
- sb_err:
  - Set on sb_set to a busy register, unless that register is being cleared in the same cycle.
  - Cleared only by reset.
- Hazard outputs:
  - rs1_busy = busy[rs1_addr], from registered state only.
  - No bypass: a register cleared this cycle reads as not busy next cycle.
- wait_cnt:
  - Cleared on a long-unit handshake.
  - Incremented when lu_wr_valid && !lu_wr_ready, saturating at STARVE_LIMIT.
  - Unchanged otherwise.
- Protocol:
  - Long unit holds valid/addr/data stable until ready.
  - Execute holds valid/addr/data stable while exec_stall.
- A WAW stall on execute frees the port for the long unit in the same cycle.
- Reset mid-handshake: a pending result is lost, and all pending scoreboard entries are cleared.

Decomposition:
- Shared package armleocpu_defs holds:
  - REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0;
  - the STARVE_LIMIT default.
- Sub-module armleocpu_regfile_scoreboard holds:
  - the busy vector with set/clear/set-wins logic;
  - two read ports;
  - sb_err generation.
- The arbiter top holds grant logic and the starvation counter.

Test Plan:
- Reset, then only exec_wr_valid=1, addr=5, data=0xDEADBEEF → same cycle rd_write=1, rd_addr=5, rd_wdata=0xDEADBEEF, exec_stall=0.
- sb_set addr=7, then exec write addr=7 → exec_stall=1 while busy[7]. Then long-unit write addr=7, data=0x11 → lu_wr_ready=1, rd_addr=7. Next cycle busy[7]=0 and execute commits.
- Execute writes addr=3 every cycle while lu_wr_valid is held → lu_wr_ready=0 for 4 cycles. On cycle 5 lu_wr_ready=1 and exec_stall=1. On cycle 6 execute resumes.
- Same-cycle sb_set addr=9 and long-unit handshake addr=9 → busy[9]=1 afterwards, rs1_busy=1 for rs1_addr=9, sb_err=0.
- sb_set addr=4 twice without a clear → sb_err=1, held until reset. Writes to x0 from both sources → rd_write=0, lu_wr_ready=1, exec_stall=0.
- Assert rst_n low while busy[12]=1 and lu_wr_valid=1 → all outputs 0 immediately. After release, rs1_busy=0 for addr 12.
